// File: rtl/moisture_pkg.sv
// Shared definitions for the moisture/pump controller slice.
//   MOIST_W      : width of moisture readings and setpoints
//   COUNT_W      : width of the watering-event counter
//   pump_state_t : controller state encoding (IDLE=0, WATER=1, SOAK=2, FAULT=3)
//   sat_deficit  : ideal - wet, floored at zero (same rule as the moisture comparator)
package moisture_pkg;
  localparam int MOIST_W = 6;
  localparam int COUNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WATER = 2'd1,
    SOAK  = 2'd2,
    FAULT = 2'd3
  } pump_state_t;

  function automatic logic [MOIST_W-1:0] sat_deficit(input logic [MOIST_W-1:0] ideal,
                                                     input logic [MOIST_W-1:0] wet);
    return (ideal > wet) ? (ideal - wet) : '0;
  endfunction
endpackage

// File: rtl/moisture_timer.sv
// Terminal-count up-counter.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to 0 (wins over en)
//   en       : count enable; wraps to 0 after reaching last
//   last     : terminal count value
//   tc       : high while the count equals last
module moisture_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         tc
);
  logic [W-1:0] cnt;

  assign tc = (cnt == last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= tc ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/moisture_pump_ctrl.sv
// Watering pump sequencer: periodic moisture sampling with hysteresis,
// maximum-on watchdog, post-watering soak delay and sticky fault.
//   clk, rst    : clock, asynchronous active-high reset
//   enable      : controller enable; low returns to IDLE with pump off
//   wet, ideal  : moisture reading and setpoint (6 bit)
//   fault_clr   : pulse that releases a latched watchdog fault
//   pump_on     : registered pump drive
//   alarm       : registered saturating deficit ideal - wet
//   busy        : registered, high in WATER or SOAK
//   fault       : registered, high in FAULT
//   water_count : completed watering events, saturating at 255
module moisture_pump_ctrl
  import moisture_pkg::*;
#(
  parameter int SAMPLE_DIV = 16,
  parameter int HYST       = 2,
  parameter int MAX_ON     = 64,
  parameter int SOAK_TIME  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [MOIST_W-1:0] wet,
  input  logic [MOIST_W-1:0] ideal,
  input  logic               fault_clr,
  output logic               pump_on,
  output logic [MOIST_W-1:0] alarm,
  output logic               busy,
  output logic               fault,
  output logic [COUNT_W-1:0] water_count
);
  localparam int TMR_MAX = (SAMPLE_DIV > SOAK_TIME) ? SAMPLE_DIV : SOAK_TIME;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam int ON_W    = $clog2(MAX_ON) + 1;

  pump_state_t state, nxt;
  logic tmr_clr, tmr_en, tmr_tc;
  logic on_clr, on_en, on_tc;
  logic alarm_ld, cnt_inc;
  logic start, wet_ok;
  logic [TMR_W-1:0] tmr_last;

  // 7-bit compare so wet + HYST cannot wrap past the setpoint.
  assign start  = ({1'b0, wet} + 7'(HYST)) < {1'b0, ideal};
  assign wet_ok = (wet >= ideal);

  // The sample and soak intervals never overlap, so one timer serves both.
  assign tmr_last = (state == SOAK) ? TMR_W'(SOAK_TIME - 1) : TMR_W'(SAMPLE_DIV - 1);

  moisture_timer #(.W(TMR_W)) u_sample_tmr (
    .clk(clk), .rst(rst), .clr(tmr_clr), .en(tmr_en), .last(tmr_last), .tc(tmr_tc)
  );

  moisture_timer #(.W(ON_W)) u_on_tmr (
    .clk(clk), .rst(rst), .clr(on_clr), .en(on_en), .last(ON_W'(MAX_ON - 1)), .tc(on_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt      = state;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    on_clr   = 1'b0;
    on_en    = 1'b0;
    alarm_ld = 1'b0;
    cnt_inc  = 1'b0;
    case (state)
      IDLE: begin
        on_clr = 1'b1;
        if (!enable) begin
          tmr_clr = 1'b1;
        end else if (tmr_tc) begin
          alarm_ld = 1'b1;
          tmr_clr  = 1'b1;
          if (start) nxt = WATER;
        end else begin
          tmr_en = 1'b1;
        end
      end
      WATER: begin
        alarm_ld = 1'b1;
        tmr_clr  = 1'b1;
        if (!enable) begin
          nxt    = IDLE;
          on_clr = 1'b1;
        end else if (wet_ok) begin
          // Moisture exit has priority over a simultaneous watchdog expiry.
          nxt     = SOAK;
          on_clr  = 1'b1;
          cnt_inc = 1'b1;
        end else if (on_tc) begin
          nxt    = FAULT;
          on_clr = 1'b1;
        end else begin
          on_en = 1'b1;
        end
      end
      SOAK: begin
        on_clr = 1'b1;
        if (!enable || tmr_tc) begin
          nxt     = IDLE;
          tmr_clr = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      FAULT: begin
        on_clr  = 1'b1;
        tmr_clr = 1'b1;
        if (fault_clr) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Status outputs follow the state register by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pump_on     <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
      alarm       <= '0;
      water_count <= '0;
    end else begin
      pump_on <= (state == WATER);
      busy    <= (state == WATER) || (state == SOAK);
      fault   <= (state == FAULT);
      if (alarm_ld) alarm <= sat_deficit(ideal, wet);
      if (cnt_inc && (water_count != {COUNT_W{1'b1}}))
        water_count <= water_count + COUNT_W'(1);
    end
  end
endmodule

// File: tb/tb_moisture_pump_ctrl.sv
// Self-checking bench for moisture_pump_ctrl: directed scenarios plus
// randomized stimulus, every cycle compared against a behavioural model.
module tb_moisture_pump_ctrl;
  localparam int SAMPLE_DIV = 16;
  localparam int HYST       = 2;
  localparam int MAX_ON     = 64;
  localparam int SOAK_TIME  = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [5:0] wet = '0;
  logic [5:0] ideal = '0;
  logic       fault_clr = 1'b0;
  logic       pump_on, busy, fault;
  logic [5:0] alarm;
  logic [7:0] water_count;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  moisture_pump_ctrl #(
    .SAMPLE_DIV(SAMPLE_DIV), .HYST(HYST), .MAX_ON(MAX_ON), .SOAK_TIME(SOAK_TIME)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .wet(wet), .ideal(ideal),
    .fault_clr(fault_clr), .pump_on(pump_on), .alarm(alarm), .busy(busy),
    .fault(fault), .water_count(water_count)
  );

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_WATER, M_SOAK, M_FAULT} mode_t;
  mode_t m_mode;
  int m_age;        // cycles since last sample restart
  int m_on_used;    // pump cycles already spent in this watering
  int m_soak_left;  // soak cycles still to go
  int m_alarm;
  int m_cnt;

  logic [16:0] exp_q[$];

  function automatic int deficit(input int id, input int w);
    return (id > w) ? id - w : 0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_age = 0; m_on_used = 0; m_soak_left = 0;
    m_alarm = 0; m_cnt = 0;
    exp_q.delete();
  endtask

  // Called at each rising edge with the inputs that edge sees.
  task automatic model_step();
    logic o_pump, o_busy, o_fault;
    int w, id;
    w  = int'(wet);
    id = int'(ideal);
    o_pump  = (m_mode == M_WATER);
    o_busy  = (m_mode == M_WATER) || (m_mode == M_SOAK);
    o_fault = (m_mode == M_FAULT);
    case (m_mode)
      M_IDLE: begin
        if (!enable) m_age = 0;
        else if (m_age == SAMPLE_DIV - 1) begin
          m_age = 0;
          m_alarm = deficit(id, w);
          if (w + HYST < id) begin m_mode = M_WATER; m_on_used = 0; end
        end else m_age++;
      end
      M_WATER: begin
        m_alarm = deficit(id, w);
        m_on_used++;
        if (!enable) begin m_mode = M_IDLE; m_age = 0; end
        else if (w >= id) begin
          m_mode = M_SOAK; m_soak_left = SOAK_TIME;
          if (m_cnt < 255) m_cnt++;
        end else if (m_on_used == MAX_ON) m_mode = M_FAULT;
      end
      M_SOAK: begin
        m_soak_left--;
        if (!enable || m_soak_left == 0) begin m_mode = M_IDLE; m_age = 0; end
      end
      M_FAULT: begin
        if (fault_clr) begin m_mode = M_IDLE; m_age = 0; end
      end
      default: m_mode = M_IDLE;
    endcase
    exp_q.push_back({o_pump, 6'(m_alarm), o_busy, o_fault, 8'(m_cnt)});
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic [16:0] e;
    e = exp_q.pop_front();
    check("pump_on", {7'd0, pump_on}, {7'd0, e[16]});
    check("alarm", {2'd0, alarm}, {2'd0, e[15:10]});
    check("busy", {7'd0, busy}, {7'd0, e[9]});
    check("fault", {7'd0, fault}, {7'd0, e[8]});
    check("water_count", water_count, e[7:0]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic set_in(input logic en, input int w, input int id);
    enable = en; wet = 6'(w); ideal = 6'(id);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check("rst_pump_on", {7'd0, pump_on}, 8'd0);
    check("rst_alarm", {2'd0, alarm}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_fault", {7'd0, fault}, 8'd0);
    check("rst_water_count", water_count, 8'd0);
    rst = 1'b0;
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    step_cycle();
    fault_clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1: basic watering cycle
    set_in(1'b1, 17, 27);
    do_reset();
    run(16);
    check("t1_alarm_at_sample", {2'd0, alarm}, 8'd10);
    check("t1_pump_before", {7'd0, pump_on}, 8'd0);
    run(1);
    check("t1_pump_on", {7'd0, pump_on}, 8'd1);
    wet = 6'd27;
    run(2);
    check("t1_pump_off", {7'd0, pump_on}, 8'd0);
    check("t1_count", water_count, 8'd1);
    run(40);

    // 2: inside hysteresis band, never waters
    set_in(1'b1, 26, 27);
    do_reset();
    run(100);
    check("t2_pump", {7'd0, pump_on}, 8'd0);
    check("t2_alarm", {2'd0, alarm}, 8'd1);

    // 3: watchdog fault, clear, restart
    set_in(1'b1, 10, 40);
    do_reset();
    run(80);
    check("t3_pump_last", {7'd0, pump_on}, 8'd1);
    run(1);
    check("t3_fault", {7'd0, fault}, 8'd1);
    check("t3_pump_off", {7'd0, pump_on}, 8'd0);
    run(5);
    pulse_clr();
    run(1);
    check("t3_fault_cleared", {7'd0, fault}, 8'd0);
    run(20);
    check("t3_rewater", {7'd0, pump_on}, 8'd1);

    // 4: moisture exit and watchdog expiry on the same cycle
    set_in(1'b1, 10, 40);
    do_reset();
    run(79);
    wet = 6'd40;
    run(1);
    check("t4_count", water_count, 8'd1);
    run(1);
    check("t4_no_fault", {7'd0, fault}, 8'd0);
    check("t4_busy", {7'd0, busy}, 8'd1);
    run(35);

    // 5: enable dropped mid-watering
    set_in(1'b1, 10, 40);
    do_reset();
    run(22);
    enable = 1'b0;
    run(2);
    check("t5_pump_off", {7'd0, pump_on}, 8'd0);
    check("t5_count", water_count, 8'd0);
    enable = 1'b1;
    run(18);
    check("t5_resample", {7'd0, pump_on}, 8'd1);

    // boundary setpoints
    set_in(1'b1, 0, 0);
    do_reset();
    run(40);
    set_in(1'b1, 63, 63);
    run(40);
    set_in(1'b1, 60, 63);
    run(40);

    // 6a: saturate the watering counter
    set_in(1'b1, 10, 40);
    do_reset();
    for (int i = 0; i < 13500; i++) begin
      wet = (m_mode == M_WATER) ? 6'd40 : 6'd10;
      step_cycle();
    end
    check("t6_saturated", water_count, 8'd255);

    // 6b: asynchronous reset while watering
    wet = 6'd10;
    for (int i = 0; i < 60 && !(m_mode == M_WATER && pump_on); i++) step_cycle();
    check("t6_in_water", {7'd0, pump_on}, 8'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_pump", {7'd0, pump_on}, 8'd0);
    check("t6_async_alarm", {2'd0, alarm}, 8'd0);
    check("t6_async_count", water_count, 8'd0);
    do_reset();

    // randomized operation
    set_in(1'b1, $urandom_range(0, 63), $urandom_range(0, 63));
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 29) == 0)  wet = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 149) == 0) ideal = 6'($urandom_range(0, 63));
      enable    = ($urandom_range(0, 99) != 0);
      fault_clr = ($urandom_range(0, 39) == 0);
      step_cycle();
    end
    fault_clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
